// File: rtl/irrigacao_pkg.sv
// Shared constants for the irrigation controller: state encodings, default
// thresholds, tank level landmarks and the state-to-output map.
package irrigacao_pkg;

   // State encodings, also exported on the estado port.
   localparam logic [2:0] ST_ENCHER  = 3'd0;
   localparam logic [2:0] ST_PRONTO  = 3'd1;
   localparam logic [2:0] ST_LIBERAR = 3'd2;
   localparam logic [2:0] ST_IRRIGAR = 3'd3;
   localparam logic [2:0] ST_PAUSA   = 3'd4;
   localparam logic [2:0] ST_FALHA   = 3'd5;

   // Default thresholds and time limits.
   localparam int unsigned LIMIAR_SECO_PAD  = 3;
   localparam int unsigned LIMIAR_UMIDO_PAD = 6;
   localparam int unsigned FILTRO_PAD       = 4;
   localparam int unsigned ACK_MAX_PAD      = 4;
   localparam int unsigned TEMPO_MAX_PAD    = 40;
   localparam int unsigned PAUSA_PAD        = 8;

   // Tank level landmarks as reported by the tank block.
   localparam logic [2:0] NIVEL_CHEIO = 3'd7;
   localparam logic [2:0] NIVEL_VAZIO = 3'd0;

   typedef struct packed {
      logic start_fill;
      logic valvula;
      logic falha;
   } saidas_t;

   // Output values associated with a state; illegal encodings map to the
   // reset values so a corrupted state never opens the valve.
   function automatic saidas_t saidas_de(input logic [2:0] st);
      saidas_t s;
      s.start_fill = 1'b1;
      s.valvula    = 1'b0;
      s.falha      = 1'b0;
      case (st)
         ST_LIBERAR: begin
            s.start_fill = 1'b0;
         end
         ST_IRRIGAR: begin
            s.start_fill = 1'b0;
            s.valvula    = 1'b1;
         end
         ST_FALHA: begin
            s.falha = 1'b1;
         end
         default: begin
         end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/controle_irrigacao_filtro.sv
// Dry-soil debounce: counts consecutive dry samples while enabled and
// flags the sample on which the count reaches FILTRO.
module filtro_umidade
   import irrigacao_pkg::*;
#(
   parameter int unsigned FILTRO = FILTRO_PAD
) (
   input  logic       Ctrl_clk,
   input  logic       reset,
   input  logic       habilita,
   input  logic [2:0] umidade,
   input  logic [2:0] limiar,
   output logic       seco_confirmado
);

   localparam logic [3:0] ALVO = 4'(FILTRO);

   logic [3:0] cnt_q, cnt_d;
   logic       seco;

   assign seco = (umidade <= limiar);

   // Count up on dry samples, saturate at the target, clear on wet or disable.
   always_comb begin
      cnt_d = cnt_q;
      if (!habilita || !seco) begin
         cnt_d = 4'd0;
      end else if (cnt_q != ALVO) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Confirmation is taken from the count being loaded so the FSM can leave
   // on the same edge that sees the last dry sample.
   assign seco_confirmado = (cnt_d == ALVO);

   // Counter register.
   always_ff @(posedge Ctrl_clk) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/controle_irrigacao.sv
// Irrigation controller: requests tank refills, releases water once the soil
// is confirmed dry, opens the field valve while the tank drains and recovers
// through a cooldown. A missing drain acknowledge or an unexpected drain stop
// latches a fault until reset.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ENCHER  | tank refilling, start_fill held high, wait for full tank
// PRONTO  | tank full, debounce dry soil readings
// LIBERAR | start_fill dropped, wait for Esvaziar acknowledge
// IRRIGAR | valve open while tank drains, bounded by TEMPO_MAX
// PAUSA   | cooldown before asking for the next refill
// FALHA   | sticky fault, left only through reset
module controle_irrigacao
   import irrigacao_pkg::*;
#(
   parameter int unsigned LIMIAR_SECO  = LIMIAR_SECO_PAD,
   parameter int unsigned LIMIAR_UMIDO = LIMIAR_UMIDO_PAD,
   parameter int unsigned FILTRO       = FILTRO_PAD,
   parameter int unsigned ACK_MAX      = ACK_MAX_PAD,
   parameter int unsigned TEMPO_MAX    = TEMPO_MAX_PAD,
   parameter int unsigned PAUSA        = PAUSA_PAD
) (
   input  logic       Ctrl_clk,
   input  logic       reset,
   input  logic [2:0] umidade,
   input  logic [2:0] nivel,
   input  logic       Esvaziar,
   output logic       start_fill,
   output logic       valvula,
   output logic       falha,
   output logic [2:0] estado
);

   // Terminal counts: each counter starts at 0 on state entry, so the event
   // fires on the sample where the counter holds LIMIT-1.
   localparam logic [2:0] SECO_L    = 3'(LIMIAR_SECO);
   localparam logic [2:0] UMIDO_L   = 3'(LIMIAR_UMIDO);
   localparam logic [3:0] ACK_FIM   = 4'(ACK_MAX - 1);
   localparam logic [7:0] TEMPO_FIM = 8'(TEMPO_MAX - 1);
   localparam logic [7:0] PAUSA_FIM = 8'(PAUSA - 1);

   logic [2:0] state_q, state_d;
   logic [3:0] ack_q, ack_d;
   logic [7:0] timer_q, timer_d;
   logic [7:0] pausa_q, pausa_d;
   logic       start_fill_q, start_fill_d;
   logic       valvula_q, valvula_d;
   logic       falha_q, falha_d;

   logic       seco_confirmado;
   logic       fim_irrigacao;
   saidas_t    saidas_d;

   filtro_umidade #(
      .FILTRO (FILTRO)
   ) u_filtro (
      .Ctrl_clk        (Ctrl_clk),
      .reset           (reset),
      .habilita        (state_q == ST_PRONTO),
      .umidade         (umidade),
      .limiar          (SECO_L),
      .seco_confirmado (seco_confirmado)
   );

   // Any of these ends irrigation normally; they outrank a drain stop, since
   // the tank block drops Esvaziar on its own once it reaches empty.
   assign fim_irrigacao = (umidade >= UMIDO_L)
                        || (nivel == NIVEL_VAZIO)
                        || (timer_q == TEMPO_FIM);

   // Next-state and timer logic; all timers restart whenever the state changes.
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      timer_d = timer_q;
      pausa_d = pausa_q;

      case (state_q)
         ST_ENCHER: begin
            if (nivel == NIVEL_CHEIO && !Esvaziar) begin
               state_d = ST_PRONTO;
            end
         end
         ST_PRONTO: begin
            if (seco_confirmado) begin
               state_d = ST_LIBERAR;
            end
         end
         ST_LIBERAR: begin
            if (Esvaziar) begin
               state_d = ST_IRRIGAR;
            end else if (ack_q == ACK_FIM) begin
               state_d = ST_FALHA;
            end else begin
               ack_d = ack_q + 4'd1;
            end
         end
         ST_IRRIGAR: begin
            if (fim_irrigacao) begin
               state_d = ST_PAUSA;
            end else if (!Esvaziar) begin
               state_d = ST_FALHA;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         ST_PAUSA: begin
            if (pausa_q == PAUSA_FIM) begin
               state_d = ST_ENCHER;
            end else begin
               pausa_d = pausa_q + 8'd1;
            end
         end
         ST_FALHA: begin
            state_d = ST_FALHA;
         end
         default: begin
            state_d = ST_ENCHER;
         end
      endcase

      if (state_d != state_q) begin
         ack_d   = 4'd0;
         timer_d = 8'd0;
         pausa_d = 8'd0;
      end
   end

   // Outputs follow the state being entered so they switch on the same edge.
   always_comb begin
      saidas_d     = saidas_de(state_d);
      start_fill_d = saidas_d.start_fill;
      valvula_d    = saidas_d.valvula;
      falha_d      = saidas_d.falha;
   end

   // State, timer and output registers.
   always_ff @(posedge Ctrl_clk) begin
      if (reset) begin
         state_q      <= ST_ENCHER;
         ack_q        <= 4'd0;
         timer_q      <= 8'd0;
         pausa_q      <= 8'd0;
         start_fill_q <= 1'b1;
         valvula_q    <= 1'b0;
         falha_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         ack_q        <= ack_d;
         timer_q      <= timer_d;
         pausa_q      <= pausa_d;
         start_fill_q <= start_fill_d;
         valvula_q    <= valvula_d;
         falha_q      <= falha_d;
      end
   end

   assign start_fill = start_fill_q;
   assign valvula    = valvula_q;
   assign falha      = falha_q;
   assign estado     = state_q;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Directed bench for controle_irrigacao. A default-parameter instance covers
// most scenarios; a second instance with TEMPO_MAX=5 shares the stimulus and
// is checked in the timeout scenario.
module tb_controle_irrigacao;

   logic       clk;
   logic       reset;
   logic [2:0] umidade;
   logic [2:0] nivel;
   logic       Esvaziar;

   logic       start_fill, valvula, falha;
   logic [2:0] estado;
   logic       start_fill_c, valvula_c, falha_c;
   logic [2:0] estado_c;

   logic [5:0] obs, obs_c;
   assign obs   = {estado, start_fill, valvula, falha};
   assign obs_c = {estado_c, start_fill_c, valvula_c, falha_c};

   int n_checks = 0;
   int n_fail   = 0;

   controle_irrigacao dut (
      .Ctrl_clk   (clk),
      .reset      (reset),
      .umidade    (umidade),
      .nivel      (nivel),
      .Esvaziar   (Esvaziar),
      .start_fill (start_fill),
      .valvula    (valvula),
      .falha      (falha),
      .estado     (estado)
   );

   controle_irrigacao #(.TEMPO_MAX(5)) dut_curto (
      .Ctrl_clk   (clk),
      .reset      (reset),
      .umidade    (umidade),
      .nivel      (nivel),
      .Esvaziar   (Esvaziar),
      .start_fill (start_fill_c),
      .valvula    (valvula_c),
      .falha      (falha_c),
      .estado     (estado_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Full tank, dry soil: PRONTO at the first edge, LIBERAR four edges later,
   // then acknowledge drain so the next edge enters IRRIGAR.
   task automatic ir_para_irrigar();
      do_reset();
      Esvaziar = 1'b0;
      umidade  = 3'd2;
      nivel    = 3'd7;
      tick();
      repeat (4) tick();
      Esvaziar = 1'b1;
      tick();
   endtask

   // obs layout: {estado[2:0], start_fill, valvula, falha}
   task automatic test_reset();
      umidade  = 3'd7;
      nivel    = 3'd0;
      Esvaziar = 1'b0;
      do_reset();
      n_checks++;
      if (obs !== 6'b000_1_0_0) begin
         n_fail++;
         $display("FAIL reset_values: got %b expected %b", obs, 6'b000_1_0_0);
      end
      tick();
      n_checks++;
      if (obs !== 6'b000_1_0_0) begin
         n_fail++;
         $display("FAIL reset_hold_encher: got %b expected %b", obs, 6'b000_1_0_0);
      end
   endtask

   task automatic test_ciclo_basico();
      do_reset();
      umidade  = 3'd2;
      Esvaziar = 1'b0;
      for (int n = 0; n < 7; n++) begin
         nivel = 3'(n);
         tick();
         n_checks++;
         if (obs !== 6'b000_1_0_0) begin
            n_fail++;
            $display("FAIL basico_encher n=%0d: got %b expected %b", n, obs, 6'b000_1_0_0);
         end
      end
      nivel = 3'd7;
      tick();
      n_checks++;
      if (obs !== 6'b001_1_0_0) begin
         n_fail++;
         $display("FAIL basico_pronto: got %b expected %b", obs, 6'b001_1_0_0);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_checks++;
         if (obs !== 6'b001_1_0_0) begin
            n_fail++;
            $display("FAIL basico_filtro k=%0d: got %b expected %b", k, obs, 6'b001_1_0_0);
         end
      end
      tick();
      n_checks++;
      if (obs !== 6'b010_0_0_0) begin
         n_fail++;
         $display("FAIL basico_liberar: got %b expected %b", obs, 6'b010_0_0_0);
      end
      tick();
      n_checks++;
      if (obs !== 6'b010_0_0_0) begin
         n_fail++;
         $display("FAIL basico_espera_ack: got %b expected %b", obs, 6'b010_0_0_0);
      end
      Esvaziar = 1'b1;
      tick();
      n_checks++;
      if (obs !== 6'b011_0_1_0) begin
         n_fail++;
         $display("FAIL basico_irrigar: got %b expected %b", obs, 6'b011_0_1_0);
      end
   endtask

   task automatic test_filtro_intermitente();
      logic [2:0] pat [8];
      logic [5:0] esp;
      pat = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd2, 3'd2, 3'd2, 3'd2};
      do_reset();
      Esvaziar = 1'b0;
      umidade  = 3'd7;
      nivel    = 3'd7;
      tick();
      for (int i = 0; i < 8; i++) begin
         umidade = pat[i];
         tick();
         esp = (i == 7) ? 6'b010_0_0_0 : 6'b001_1_0_0;
         n_checks++;
         if (obs !== esp) begin
            n_fail++;
            $display("FAIL filtro_padrao i=%0d: got %b expected %b", i, obs, esp);
         end
      end
   endtask

   task automatic test_umido_pausa();
      ir_para_irrigar();
      for (int k = 1; k <= 9; k++) begin
         tick();
         n_checks++;
         if (obs !== 6'b011_0_1_0) begin
            n_fail++;
            $display("FAIL umido_irrigando k=%0d: got %b expected %b", k, obs, 6'b011_0_1_0);
         end
      end
      umidade = 3'd6;
      tick();
      n_checks++;
      if (obs !== 6'b100_1_0_0) begin
         n_fail++;
         $display("FAIL umido_para_pausa: got %b expected %b", obs, 6'b100_1_0_0);
      end
      umidade  = 3'd2;
      nivel    = 3'd0;
      Esvaziar = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         n_checks++;
         if (obs !== 6'b100_1_0_0) begin
            n_fail++;
            $display("FAIL pausa_contando k=%0d: got %b expected %b", k, obs, 6'b100_1_0_0);
         end
      end
      tick();
      n_checks++;
      if (obs !== 6'b000_1_0_0) begin
         n_fail++;
         $display("FAIL pausa_fim_encher: got %b expected %b", obs, 6'b000_1_0_0);
      end
      tick();
      n_checks++;
      if (obs !== 6'b000_1_0_0) begin
         n_fail++;
         $display("FAIL encher_espera_cheio: got %b expected %b", obs, 6'b000_1_0_0);
      end
   endtask

   task automatic test_tempo_max();
      logic [2:0] niveis [5];
      int aberto;
      niveis = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd3};
      ir_para_irrigar();
      umidade = 3'd1;
      aberto  = (valvula_c === 1'b1) ? 1 : 0;
      for (int k = 1; k <= 5; k++) begin
         nivel = niveis[k-1];
         tick();
         if (valvula_c === 1'b1) aberto++;
      end
      n_checks++;
      if (obs_c !== 6'b100_1_0_0) begin
         n_fail++;
         $display("FAIL tempo_max_pausa: got %b expected %b", obs_c, 6'b100_1_0_0);
      end
      n_checks++;
      if (aberto !== 5) begin
         n_fail++;
         $display("FAIL tempo_max_ciclos_abertos: got %0d expected 5", aberto);
      end
      n_checks++;
      if (obs !== 6'b011_0_1_0) begin
         n_fail++;
         $display("FAIL tempo_longo_ainda_irriga: got %b expected %b", obs, 6'b011_0_1_0);
      end
   endtask

   task automatic test_nivel_vazio();
      ir_para_irrigar();
      tick();
      nivel    = 3'd0;
      Esvaziar = 1'b0;
      tick();
      n_checks++;
      if (obs !== 6'b100_1_0_0) begin
         n_fail++;
         $display("FAIL vazio_para_pausa: got %b expected %b", obs, 6'b100_1_0_0);
      end
   endtask

   task automatic test_esvaziar_cai();
      ir_para_irrigar();
      tick();
      nivel    = 3'd4;
      Esvaziar = 1'b0;
      tick();
      n_checks++;
      if (obs !== 6'b101_1_0_1) begin
         n_fail++;
         $display("FAIL esvaziar_cai_falha: got %b expected %b", obs, 6'b101_1_0_1);
      end
   endtask

   task automatic test_falha_ack();
      do_reset();
      Esvaziar = 1'b0;
      umidade  = 3'd2;
      nivel    = 3'd7;
      tick();
      repeat (4) tick();
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_checks++;
         if (obs !== 6'b010_0_0_0) begin
            n_fail++;
            $display("FAIL ack_esperando k=%0d: got %b expected %b", k, obs, 6'b010_0_0_0);
         end
      end
      tick();
      n_checks++;
      if (obs !== 6'b101_1_0_1) begin
         n_fail++;
         $display("FAIL ack_timeout_falha: got %b expected %b", obs, 6'b101_1_0_1);
      end
      Esvaziar = 1'b1;
      umidade  = 3'd7;
      nivel    = 3'd0;
      repeat (6) tick();
      n_checks++;
      if (obs !== 6'b101_1_0_1) begin
         n_fail++;
         $display("FAIL falha_persistente: got %b expected %b", obs, 6'b101_1_0_1);
      end
      Esvaziar = 1'b0;
      do_reset();
      n_checks++;
      if (obs !== 6'b000_1_0_0) begin
         n_fail++;
         $display("FAIL falha_reset_limpa: got %b expected %b", obs, 6'b000_1_0_0);
      end
   endtask

   task automatic test_reset_irrigar();
      ir_para_irrigar();
      repeat (2) tick();
      n_checks++;
      if (obs !== 6'b011_0_1_0) begin
         n_fail++;
         $display("FAIL pre_reset_irrigar: got %b expected %b", obs, 6'b011_0_1_0);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (obs !== 6'b000_1_0_0) begin
         n_fail++;
         $display("FAIL reset_em_irrigar: got %b expected %b", obs, 6'b000_1_0_0);
      end
   endtask

   initial begin
      reset    = 1'b1;
      umidade  = 3'd7;
      nivel    = 3'd0;
      Esvaziar = 1'b0;
      #2;
      test_reset();
      test_ciclo_basico();
      test_filtro_intermitente();
      test_umido_pausa();
      test_tempo_max();
      test_nivel_vazio();
      test_esvaziar_cai();
      test_falha_ack();
      test_reset_irrigar();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
